tmds_channel_encoder: RTL and testbench

Single-channel TMDS transmit encoder. It is the inverse of the receive-side 8b10b/TERC4 decoder. Each clk it takes one symbol request (video byte, sync/control pair, TERC4 nibble or guard band) and produces the 10-bit TMDS word, LSB first on the wire, for a downstream serializer. Video data is DC-balanced with a running disparity counter. Three instances (CHANNEL 0/1/2) form an HDMI/DVI source.

---
 rtl/tmds_channel_encoder.sv | 96 +++++++++
 tb/tb_tmds_channel_encoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: single-lane TMDS encoder for video, control, TERC4 and guard-band symbols,
// with a two-register pipeline and running-disparity DC balance on video.
module tmds_channel_encoder #(
   parameter int CHANNEL = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        mode,
   input  logic [7:0]        data,
   input  logic [1:0]        ctrl,
   input  logic [3:0]        terc4,
   output logic [9:0]        out,
   output logic signed [4:0] disparity
);
   localparam logic [2:0] MODE_CTRL   = 3'd0;
   localparam logic [2:0] MODE_VIDEO  = 3'd1;
   localparam logic [2:0] MODE_TERC4  = 3'd2;
   localparam logic [2:0] MODE_VGUARD = 3'd3;
   localparam logic [2:0] MODE_DGUARD = 3'd4;
   localparam logic [9:0] CTRL_CODE [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
   localparam logic [9:0] TERC4_CODE [16] = '{
      10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

   // Transition-minimised word: XNOR chain when the byte is ones-heavy, flagged by q_m[8]=0.
   function automatic logic [8:0] minimise(input logic [7:0] d);
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1 = 4'($countones(d));
      use_xnor = n1 > 4'd4 || (n1 == 4'd4 && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic [8:0]        q_m_d, q_m_q;
   logic [2:0]        mode_q;
   logic [1:0]        ctrl_q;
   logic [3:0]        terc4_q;
   logic [9:0]        out_d, out_q;
   logic signed [4:0] cnt_d, cnt_q, ones, diff;
   logic [7:0]        q;
   logic              q8;

   always_comb q_m_d = minimise(data);

   always_comb begin
      q = q_m_q[7:0];
      q8 = q_m_q[8];
      ones = 5'($countones(q));
      diff = ones + ones - 5'sd8;
      out_d = CTRL_CODE[ctrl_q];
      cnt_d = '0;
      if (mode_q == MODE_VIDEO) begin
         if (cnt_q == 5'sd0 || diff == 5'sd0) begin
            out_d = {~q8, q8, q8 ? q : ~q};
            cnt_d = q8 ? cnt_q + diff : cnt_q - diff;
         end else if ((cnt_q > 5'sd0 && diff > 5'sd0) || (cnt_q < 5'sd0 && diff < 5'sd0)) begin
            out_d = {1'b1, q8, ~q};
            cnt_d = cnt_q - diff + (q8 ? 5'sd2 : 5'sd0);
         end else begin
            out_d = {1'b0, q8, q};
            cnt_d = cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
         end
      end else if (mode_q == MODE_TERC4) begin
         out_d = TERC4_CODE[terc4_q];
      end else if (mode_q == MODE_VGUARD) begin
         out_d = (CHANNEL == 1) ? 10'h133 : 10'h2CC;
      end else if (mode_q == MODE_DGUARD) begin
         out_d = (CHANNEL == 0) ? TERC4_CODE[{2'b11, ctrl_q}] : 10'h133;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_m_q   <= '0;
         mode_q  <= MODE_CTRL;
         ctrl_q  <= '0;
         terc4_q <= '0;
         out_q   <= 10'h354;
         cnt_q   <= '0;
      end else begin
         q_m_q   <= q_m_d;
         mode_q  <= mode;
         ctrl_q  <= ctrl;
         terc4_q <= terc4;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out = out_q;
   assign disparity = cnt_q;
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed vectors on all three lanes plus a random video run checked by a model decoder.
module tb_tmds_channel_encoder;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [2:0]        mode = '0;
   logic [7:0]        data = '0;
   logic [1:0]        ctrl = '0;
   logic [3:0]        terc4 = '0;
   logic [9:0]        out0, out1, out2;
   logic signed [4:0] disp0, disp1, disp2;
   int                n_vec = 0;
   int                n_err = 0;

   localparam logic [9:0] T4 [16] = '{
      10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
      10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

   typedef struct {
      logic [9:0]        e0, e1, e2;
      logic signed [4:0] d;
   } exp_t;
   exp_t pipe[$];

   always #5 clk = ~clk;

   tmds_channel_encoder #(.CHANNEL(0)) u_ch0 (.clk(clk), .reset(reset), .mode(mode), .data(data),
      .ctrl(ctrl), .terc4(terc4), .out(out0), .disparity(disp0));
   tmds_channel_encoder #(.CHANNEL(1)) u_ch1 (.clk(clk), .reset(reset), .mode(mode), .data(data),
      .ctrl(ctrl), .terc4(terc4), .out(out1), .disparity(disp1));
   tmds_channel_encoder #(.CHANNEL(2)) u_ch2 (.clk(clk), .reset(reset), .mode(mode), .data(data),
      .ctrl(ctrl), .terc4(terc4), .out(out2), .disparity(disp2));

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] decode(input logic [9:0] w);
      logic [7:0] q, d;
      q = w[9] ? ~w[7:0] : w[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = w[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   function automatic exp_t mk(input logic [9:0] e0, e1, e2, input logic signed [4:0] d);
      exp_t x;
      x.e0 = e0;
      x.e1 = e1;
      x.e2 = e2;
      x.d = d;
      return x;
   endfunction

   // Each vector's expectation surfaces one step after the next vector is applied.
   task automatic send(input logic [2:0] m, input logic [7:0] dt, input logic [1:0] c, input logic [3:0] t,
                       input logic [9:0] e0, e1, e2, input logic signed [4:0] d);
      exp_t x;
      mode = m;
      data = dt;
      ctrl = c;
      terc4 = t;
      pipe.push_back(mk(e0, e1, e2, d));
      step();
      if (pipe.size() == 2) begin
         x = pipe.pop_front();
         check("out0", 16'(out0), 16'(x.e0));
         check("out1", 16'(out1), 16'(x.e1));
         check("out2", 16'(out2), 16'(x.e2));
         check("disp", 16'(disp0), 16'(x.d));
      end
   endtask

   task automatic send1(input logic [2:0] m, input logic [7:0] dt, input logic [1:0] c, input logic [3:0] t,
                        input logic [9:0] e, input logic signed [4:0] d);
      send(m, dt, c, t, e, e, e, d);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      mode = '0;
      ctrl = '0;
      pipe.delete();
      repeat (n) begin
         step();
         check("rst_out", 16'(out0), 16'h354);
         check("rst_disp", 16'(disp0), 16'h0);
      end
      reset = 1'b0;
      pipe.push_back(mk(10'h354, 10'h354, 10'h354, 5'sd0));
   endtask

   initial begin
      logic [7:0] hist[$];
      logic [7:0] d;
      int         run;
      do_reset(3);
      send1(3'd0, 8'h00, 2'b00, 4'h0, 10'h354, 5'sd0);
      send1(3'd0, 8'h00, 2'b00, 4'h0, 10'h354, 5'sd0);
      send1(3'd1, 8'h00, 2'b00, 4'h0, 10'h100, -5'sd8);
      send1(3'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 5'sd2);
      send1(3'd1, 8'h00, 2'b00, 4'h0, 10'h100, -5'sd6);
      send1(3'd0, 8'h00, 2'b00, 4'h0, 10'h354, 5'sd0);
      send1(3'd0, 8'h00, 2'b01, 4'h0, 10'h0AB, 5'sd0);
      send1(3'd0, 8'h00, 2'b10, 4'h0, 10'h154, 5'sd0);
      send1(3'd0, 8'h00, 2'b11, 4'h0, 10'h2AB, 5'sd0);
      send1(3'd5, 8'h00, 2'b01, 4'h0, 10'h0AB, 5'sd0);
      send1(3'd1, 8'h00, 2'b00, 4'h0, 10'h100, -5'sd8);
      send1(3'd1, 8'hFF, 2'b00, 4'h0, 10'h0FF, -5'sd2);
      send1(3'd1, 8'h55, 2'b00, 4'h0, 10'h133, -5'sd2);
      for (int i = 0; i < 16; i++) send1(3'd2, 8'h00, 2'b00, 4'(i), T4[i], 5'sd0);
      send(3'd4, 8'h00, 2'b10, 4'h0, 10'h163, 10'h133, 10'h133, 5'sd0);
      send(3'd4, 8'h00, 2'b00, 4'h0, 10'h28E, 10'h133, 10'h133, 5'sd0);
      send(3'd3, 8'h00, 2'b00, 4'h0, 10'h2CC, 10'h133, 10'h2CC, 5'sd0);
      send1(3'd0, 8'h00, 2'b00, 4'h0, 10'h354, 5'sd0);
      do_reset(1);
      run = 0;
      for (int i = 0; i < 10000; i++) begin
         mode = 3'd1;
         data = 8'($urandom_range(0, 255));
         hist.push_back(data);
         step();
         if (hist.size() == 2) begin
            d = hist.pop_front();
            check("dec0", 16'(decode(out0)), 16'(d));
            check("dec2", 16'(decode(out2)), 16'(d));
            run += 2 * $countones(out0) - 10;
            check("balance", 16'(run), 16'(disp0));
            check("bound", {15'b0, disp0 <= 5'sd10 && disp0 >= -5'sd10}, 16'd1);
         end
      end
      reset = 1'b1;
      step();
      check("midrst_out", 16'(out0), 16'h354);
      check("midrst_disp", 16'(disp0), 16'h0);
      reset = 1'b0;
      mode = 3'd0;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
